// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: FSM states, funct3 size codes and shared defaults for the memory access unit
package mem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam int WAIT_LIMIT_DEFAULT = 64;
  // Loads treat 100/101 as unsigned byte/half; stores only know 000/001, everything else is a word
  function automatic size_t access_size(input logic store, input logic [2:0] funct3);
    return store ? (funct3 == SB ? SZ_B : funct3 == SH ? SZ_H : SZ_W)
                 : (funct3[1:0] == LB[1:0] ? SZ_B : funct3[1:0] == LH[1:0] ? SZ_H : SZ_W);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline-side request, data-cache and status signals of the memory access unit
interface mem_access_unit_if;
  logic        MEM_READ_IN, MEM_WRITE_IN;
  logic [2:0]  FUNCT3_IN;
  logic [31:0] ADDRESS_IN, STORE_DATA_IN;
  logic        DCACHE_READ, DCACHE_WRITE;
  logic [31:0] DCACHE_ADDRESS, DCACHE_WRITEDATA;
  logic [3:0]  DCACHE_BYTE_EN;
  logic [31:0] DCACHE_READDATA;
  logic        DCACHE_BUSYWAIT;
  logic        BUSYWAIT;
  logic [31:0] LOAD_DATA_OUT;
  logic        MISALIGN_OUT, TIMEOUT_OUT;
  modport master (
    output MEM_READ_IN, MEM_WRITE_IN, FUNCT3_IN, ADDRESS_IN, STORE_DATA_IN, DCACHE_READDATA, DCACHE_BUSYWAIT,
    input  DCACHE_READ, DCACHE_WRITE, DCACHE_ADDRESS, DCACHE_WRITEDATA, DCACHE_BYTE_EN,
    input  BUSYWAIT, LOAD_DATA_OUT, MISALIGN_OUT, TIMEOUT_OUT
  );
  modport slave (
    input  MEM_READ_IN, MEM_WRITE_IN, FUNCT3_IN, ADDRESS_IN, STORE_DATA_IN, DCACHE_READDATA, DCACHE_BUSYWAIT,
    output DCACHE_READ, DCACHE_WRITE, DCACHE_ADDRESS, DCACHE_WRITEDATA, DCACHE_BYTE_EN,
    output BUSYWAIT, LOAD_DATA_OUT, MISALIGN_OUT, TIMEOUT_OUT
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: selects the byte/half lane of a cache word and sign- or zero-extends it
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rdata[31:16] : rdata[15:0];
  assign data = funct3 == LB  ? {{24{b[7]}}, b}
              : funct3 == LH  ? {{16{h[15]}}, h}
              : funct3 == LBU ? {24'd0, b}
              : funct3 == LHU ? {16'd0, h}
              : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store FSM with cache watchdog; define MISALIGN_TRAP_EN to trap misaligned accesses
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input logic CLK,
  input logic RESET,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  state_t state;
  logic [CW-1:0] wd_cnt;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic is_load_q, req, is_store;
  size_t size;
  logic [31:0] wdata, fmt_data;
  logic [3:0] ben;
  assign req = bus.MEM_READ_IN | bus.MEM_WRITE_IN;
  assign is_store = bus.MEM_WRITE_IN;
  assign size = access_size(is_store, bus.FUNCT3_IN);
`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = size == SZ_H ? bus.ADDRESS_IN[0] : size == SZ_W ? |bus.ADDRESS_IN[1:0] : 1'b0;
`else
  localparam logic misalign = 1'b0;
`endif
  assign wdata = size == SZ_B ? {4{bus.STORE_DATA_IN[7:0]}}
               : size == SZ_H ? {2{bus.STORE_DATA_IN[15:0]}}
               : bus.STORE_DATA_IN;
  assign ben = size == SZ_B ? 4'b0001 << bus.ADDRESS_IN[1:0]
             : size == SZ_H ? 4'b0011 << {bus.ADDRESS_IN[1], 1'b0}
             : 4'b1111;
  assign bus.BUSYWAIT = RESET & ((state == IDLE & req) | state == ACCESS | state == WAIT);
  load_formatter u_fmt (
    .funct3(f3_q),
    .lane  (lane_q),
    .rdata (bus.DCACHE_READDATA),
    .data  (fmt_data)
  );
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      wd_cnt <= '0;
      f3_q <= '0;
      lane_q <= '0;
      is_load_q <= 1'b0;
      bus.DCACHE_READ <= 1'b0;
      bus.DCACHE_WRITE <= 1'b0;
      bus.DCACHE_ADDRESS <= '0;
      bus.DCACHE_WRITEDATA <= '0;
      bus.DCACHE_BYTE_EN <= '0;
      bus.LOAD_DATA_OUT <= '0;
      bus.MISALIGN_OUT <= 1'b0;
      bus.TIMEOUT_OUT <= 1'b0;
    end else begin
      bus.MISALIGN_OUT <= state == IDLE && req && misalign;
      case (state)
        IDLE: if (req) begin
          f3_q <= bus.FUNCT3_IN;
          lane_q <= bus.ADDRESS_IN[1:0];
          is_load_q <= !is_store;
          if (misalign) begin
            state <= DONE;
            if (!is_store) bus.LOAD_DATA_OUT <= '0;
          end else begin
            state <= ACCESS;
            bus.DCACHE_READ <= !is_store;
            bus.DCACHE_WRITE <= is_store;
            bus.DCACHE_ADDRESS <= {bus.ADDRESS_IN[31:2], 2'b00};
            bus.DCACHE_WRITEDATA <= wdata;
            bus.DCACHE_BYTE_EN <= ben;
          end
        end
        ACCESS, WAIT: begin
          if (!bus.DCACHE_BUSYWAIT) begin
            state <= DONE;
            bus.DCACHE_READ <= 1'b0;
            bus.DCACHE_WRITE <= 1'b0;
            if (is_load_q) bus.LOAD_DATA_OUT <= fmt_data;
          end else if (state == WAIT && wd_cnt == CW'(WAIT_LIMIT - 1)) begin
            state <= DONE;
            bus.DCACHE_READ <= 1'b0;
            bus.DCACHE_WRITE <= 1'b0;
            bus.LOAD_DATA_OUT <= '0;
            bus.TIMEOUT_OUT <= 1'b1;
          end else begin
            state <= WAIT;
            wd_cnt <= state == ACCESS ? '0 : wd_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a behavioural cache/format model
module tb_mem_access_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;
  mem_access_unit_if a_if ();
  mem_access_unit_if b_if ();
  mem_access_unit u_a (.CLK(CLK), .RESET(RESET), .bus(a_if.slave));
  mem_access_unit #(.WAIT_LIMIT(4)) u_b (.CLK(CLK), .RESET(RESET), .bus(b_if.slave));
  int n_asserts = 0;
  int n_fails = 0;
  logic [31:0] held_load = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic st, input logic [2:0] f3);
    if (st) return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
    return f3 == 3'd0 || f3 == 3'd4 ? 1 : f3 == 3'd1 || f3 == 3'd5 ? 2 : 4;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * addr[1:0])) & 32'hFF;
    h = (rd >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 32'd128 ? b - 32'd256 : b;
      3'd1: return h >= 32'h8000 ? h - 32'h10000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic access(input string tag, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd, input int busy);
    logic st, trap, unstable, r0, w0;
    int sz, stalls, strobes;
    logic [31:0] a0, wd0;
    logic [3:0] be0;
    st = w;
    sz = size_of(st, f3);
    trap = 1'b0;
    unstable = 1'b0;
    stalls = 0;
    strobes = 0;
    {r0, w0, a0, wd0, be0} = '0;
`ifdef MISALIGN_TRAP_EN
    trap = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`endif
    @(negedge CLK);
    a_if.MEM_READ_IN = r;
    a_if.MEM_WRITE_IN = w;
    a_if.FUNCT3_IN = f3;
    a_if.ADDRESS_IN = addr;
    a_if.STORE_DATA_IN = sd;
    a_if.DCACHE_READDATA = rd;
    for (int c = 0; c < 200; c++) begin
      if (a_if.DCACHE_READ || a_if.DCACHE_WRITE) begin
        if (strobes == 0) {r0, w0, a0, wd0, be0} = {a_if.DCACHE_READ, a_if.DCACHE_WRITE, a_if.DCACHE_ADDRESS, a_if.DCACHE_WRITEDATA, a_if.DCACHE_BYTE_EN};
        else if ({r0, w0, a0, wd0, be0} !== {a_if.DCACHE_READ, a_if.DCACHE_WRITE, a_if.DCACHE_ADDRESS, a_if.DCACHE_WRITEDATA, a_if.DCACHE_BYTE_EN}) unstable = 1'b1;
        a_if.DCACHE_BUSYWAIT = strobes < busy;
        strobes++;
      end else a_if.DCACHE_BUSYWAIT = 1'b0;
      #1;
      if (!a_if.BUSYWAIT) break;
      stalls++;
      @(negedge CLK);
    end
    chk({tag, " stalls"}, stalls, trap ? 1 : 2 + busy);
    chk({tag, " strobe cycles"}, strobes, trap ? 0 : 1 + busy);
    chk({tag, " strobes in DONE"}, {a_if.DCACHE_READ, a_if.DCACHE_WRITE}, 2'b00);
    chk({tag, " misalign"}, a_if.MISALIGN_OUT, trap);
    if (!st) held_load = trap ? 32'd0 : fmt_load(f3, addr, rd);
    chk({tag, " load data"}, a_if.LOAD_DATA_OUT, held_load);
    if (!trap) begin
      chk({tag, " strobe kind"}, {r0, w0}, {!st, st});
      chk({tag, " cache addr"}, a0, {addr[31:2], 2'b00});
      chk({tag, " stable"}, unstable, 1'b0);
      if (st) begin
        chk({tag, " wdata"}, wd0, sz == 1 ? sd[7:0] * 32'h01010101 : sz == 2 ? sd[15:0] * 32'h00010001 : sd);
        chk({tag, " byte en"}, be0, sz == 1 ? 4'(1 << addr[1:0]) : sz == 2 ? 4'(3 << (2 * addr[1])) : 4'hF);
      end
    end
    a_if.MEM_READ_IN = 1'b0;
    a_if.MEM_WRITE_IN = 1'b0;
    a_if.DCACHE_BUSYWAIT = 1'b0;
  endtask

  initial begin
    int stalls, k;
    {a_if.MEM_READ_IN, a_if.MEM_WRITE_IN, a_if.FUNCT3_IN, a_if.ADDRESS_IN, a_if.STORE_DATA_IN, a_if.DCACHE_READDATA, a_if.DCACHE_BUSYWAIT} = '0;
    {b_if.MEM_READ_IN, b_if.MEM_WRITE_IN, b_if.FUNCT3_IN, b_if.ADDRESS_IN, b_if.STORE_DATA_IN, b_if.DCACHE_READDATA, b_if.DCACHE_BUSYWAIT} = '0;
    repeat (3) @(negedge CLK);
    a_if.MEM_READ_IN = 1'b1;
    #1;
    chk("reset busywait", a_if.BUSYWAIT, 1'b0);
    chk("reset outputs A", {a_if.DCACHE_READ, a_if.DCACHE_WRITE, a_if.DCACHE_ADDRESS, a_if.DCACHE_WRITEDATA, a_if.DCACHE_BYTE_EN, a_if.LOAD_DATA_OUT, a_if.MISALIGN_OUT, a_if.TIMEOUT_OUT}, 0);
    chk("reset outputs B", {b_if.DCACHE_READ, b_if.DCACHE_WRITE, b_if.BUSYWAIT, b_if.LOAD_DATA_OUT, b_if.TIMEOUT_OUT}, 0);
    a_if.MEM_READ_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    access("LW hit", 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("LW hit const", a_if.LOAD_DATA_OUT, 32'hDEADBEEF);
    access("LB", 1, 0, 3'd0, 32'h103, 0, 32'h80123456, 0);
    chk("LB const", a_if.LOAD_DATA_OUT, 32'hFFFFFF80);
    access("LBU", 1, 0, 3'd4, 32'h103, 0, 32'h80123456, 0);
    chk("LBU const", a_if.LOAD_DATA_OUT, 32'h00000080);
    access("LHU", 1, 0, 3'd5, 32'h102, 0, 32'hBEEF1234, 0);
    chk("LHU const", a_if.LOAD_DATA_OUT, 32'h0000BEEF);
    access("SB", 0, 1, 3'd0, 32'h101, 32'h000000AB, 0, 0);
    chk("SB keeps load", a_if.LOAD_DATA_OUT, 32'h0000BEEF);
    access("LW busy5", 1, 0, 3'd2, 32'h240, 0, 32'h13579BDF, 5);
    access("SH", 0, 1, 3'd1, 32'h3FE, 32'h1234CAFE, 0, 2);
    access("both store", 1, 1, 3'd2, 32'h500, 32'hA5A55A5A, 32'hFFFFFFFF, 1);
    access("LW misaligned", 1, 0, 3'd2, 32'h102, 0, 32'h11223344, 0);
    access("LH odd", 1, 0, 3'd1, 32'h101, 0, 32'h8001FF7F, 0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      access($sformatf("rand%0d", i), k != 1, k != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end
    @(negedge CLK);
    #1;
    chk("idle quiet", {a_if.BUSYWAIT, a_if.DCACHE_READ, a_if.DCACHE_WRITE, a_if.TIMEOUT_OUT}, 4'b0000);
    b_if.MEM_READ_IN = 1'b1;
    b_if.FUNCT3_IN = 3'd2;
    b_if.ADDRESS_IN = 32'h200;
    b_if.DCACHE_READDATA = 32'h12345678;
    b_if.DCACHE_BUSYWAIT = 1'b1;
    stalls = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!b_if.BUSYWAIT) break;
      stalls++;
      @(negedge CLK);
    end
    chk("timeout stalls", stalls, 2 + 4);
    chk("timeout flag", b_if.TIMEOUT_OUT, 1'b1);
    chk("timeout load", b_if.LOAD_DATA_OUT, 32'd0);
    chk("timeout strobe", {b_if.DCACHE_READ, b_if.DCACHE_WRITE}, 2'b00);
    b_if.MEM_READ_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("timeout sticky", b_if.TIMEOUT_OUT, 1'b1);
    a_if.MEM_READ_IN = 1'b1;
    a_if.FUNCT3_IN = 3'd2;
    a_if.ADDRESS_IN = 32'h300;
    a_if.DCACHE_BUSYWAIT = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid-access strobe", a_if.DCACHE_READ, 1'b1);
    RESET = 1'b0;
    #1;
    chk("busywait in reset", a_if.BUSYWAIT, 1'b0);
    @(negedge CLK);
    chk("mid reset outputs A", {a_if.BUSYWAIT, a_if.DCACHE_READ, a_if.DCACHE_WRITE, a_if.DCACHE_ADDRESS, a_if.DCACHE_WRITEDATA, a_if.DCACHE_BYTE_EN, a_if.LOAD_DATA_OUT, a_if.MISALIGN_OUT, a_if.TIMEOUT_OUT}, 0);
    chk("reset clears timeout", b_if.TIMEOUT_OUT, 1'b0);
    held_load = '0;
    a_if.MEM_READ_IN = 1'b0;
    a_if.DCACHE_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    access("recovery LH", 1, 0, 3'd1, 32'h402, 0, 32'h9ABC0000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
